// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: address width, reset vector and PC FSM states.
package cpu_pkg;

   localparam int unsigned PC_WIDTH = 16;
   localparam logic [PC_WIDTH-1:0] PC_RESET_VECTOR = '0;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_t;

endpackage

// File: rtl/program_counter_if.sv
// Control and fetch-handshake bundle between the program counter and its surroundings.
interface program_counter_if #(
   parameter int unsigned WIDTH = 16
);
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_addr;
   logic             halt;
   logic             resume;
   logic [WIDTH-1:0] pc;
   logic             pc_valid;
   logic             pc_ready;
   logic             halted;
   logic             wrap;

   // The program counter is the master of the fetch handshake.
   modport master (
      input  clear, load, load_addr, halt, resume, pc_ready,
      output pc, pc_valid, halted, wrap
   );

   modport slave (
      output clear, load, load_addr, halt, resume, pc_ready,
      input  pc, pc_valid, halted, wrap
   );
endinterface

// File: rtl/program_counter_next_select.sv
// Combinational next-pc priority selector (clear > load > increment > hold) and wrap detect.
module pc_next_select #(
   parameter int unsigned      WIDTH        = 16,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic             clear_i,
   input  logic             load_i,
   input  logic             inc_i,
   input  logic [WIDTH-1:0] pc_q_i,
   input  logic [WIDTH-1:0] load_addr_i,
   output logic [WIDTH-1:0] pc_d_o,
   output logic             wrap_d_o
);
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] mux_inc;
   logic [WIDTH-1:0] mux_load;
   logic             all_ones;

   assign pc_inc   = pc_q_i + {{(WIDTH-1){1'b0}}, 1'b1};
   assign all_ones = &pc_q_i;

   // Mux chain, lowest priority innermost.
   assign mux_inc  = inc_i   ? pc_inc       : pc_q_i;
   assign mux_load = load_i  ? load_addr_i  : mux_inc;
   assign pc_d_o   = clear_i ? RESET_VECTOR : mux_load;

   assign wrap_d_o = inc_i & all_ones & ~load_i & ~clear_i;
endmodule

// File: rtl/program_counter.sv
// Registered fetch-address generator with BOOT/RUN/HALT issue control.
//   state | meaning
//   BOOT  | one cycle after reset/clear, no address offered
//   RUN   | pc offered to fetch, increments on handshake
//   HALT  | issue stopped, load still honoured
module program_counter
   import cpu_pkg::*;
#(
   parameter int unsigned      WIDTH        = PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR
) (
   input  logic              clk,
   input  logic              rst_n,
   program_counter_if.master pc_if
);
   pc_state_t        state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             wrap_q, wrap_d;
   logic             pc_valid, halted;
   logic             inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (pc_if.clear) begin
         state_d = BOOT;
      end else begin
         case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (pc_if.halt) state_d = HALT;
            HALT:    if (pc_if.resume && !pc_if.halt) state_d = RUN;
            default: state_d = BOOT;
         endcase
      end
   end

   always_comb begin
      pc_valid = (state_q == RUN);
      halted   = (state_q == HALT);
   end

   // pc_ready only counts while an address is actually offered.
   assign inc = pc_valid & pc_if.pc_ready;

   pc_next_select #(
      .WIDTH        (WIDTH),
      .RESET_VECTOR (RESET_VECTOR)
   ) u_next (
      .clear_i     (pc_if.clear),
      .load_i      (pc_if.load),
      .inc_i       (inc),
      .pc_q_i      (pc_q),
      .load_addr_i (pc_if.load_addr),
      .pc_d_o      (pc_d),
      .wrap_d_o    (wrap_d)
   );

   assign pc_if.pc       = pc_q;
   assign pc_if.pc_valid = pc_valid;
   assign pc_if.halted   = halted;
   assign pc_if.wrap     = wrap_q;
endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter with hand-computed expectations.
module tb_program_counter;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   program_counter_if #(.WIDTH(16)) pc_if ();

   program_counter #(.WIDTH(16), .RESET_VECTOR(16'h0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pc_if (pc_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic clr, input logic ld, input logic [15:0] addr,
                        input logic rdy, input logic hlt, input logic rsm);
      pc_if.clear     = clr;
      pc_if.load      = ld;
      pc_if.load_addr = addr;
      pc_if.pc_ready  = rdy;
      pc_if.halt      = hlt;
      pc_if.resume    = rsm;
   endtask

   initial begin
      logic [15:0] exp_seq [5];
      logic        rdy_seq [5];
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      drive(0, 0, 16'h0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      check("rst_pc", pc_if.pc, 16'h0000);
      check("rst_valid", pc_if.pc_valid, 0);
      check("rst_halted", pc_if.halted, 0);
      check("rst_wrap", pc_if.wrap, 0);
      step();
      check("boot_valid", pc_if.pc_valid, 1);
      check("boot_pc", pc_if.pc, 16'h0000);

      rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_seq = '{16'h1, 16'h1, 16'h1, 16'h2, 16'h3};
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 16'h0, rdy_seq[i], 0, 0);
         step();
         check($sformatf("stream_pc[%0d]", i), pc_if.pc, exp_seq[i]);
         check($sformatf("stream_valid[%0d]", i), pc_if.pc_valid, 1);
      end

      drive(0, 1, 16'h0010, 0, 0, 0);
      step();
      check("load_stall_pc", pc_if.pc, 16'h0010);
      drive(0, 1, 16'h1234, 1, 0, 0);
      step();
      check("load_hs_pc", pc_if.pc, 16'h1234);
      drive(0, 1, 16'h2000, 0, 0, 0);
      step();
      check("load_stall2_pc", pc_if.pc, 16'h2000);
      check("load_stall2_valid", pc_if.pc_valid, 1);

      drive(0, 1, 16'hFFFF, 0, 0, 0);
      step();
      check("wrap_pre_pc", pc_if.pc, 16'hFFFF);
      check("wrap_pre", pc_if.wrap, 0);
      drive(0, 0, 16'h0, 1, 0, 0);
      step();
      check("wrap_pc", pc_if.pc, 16'h0000);
      check("wrap_pulse", pc_if.wrap, 1);
      drive(0, 0, 16'h0, 0, 0, 0);
      step();
      check("wrap_drop", pc_if.wrap, 0);
      check("wrap_hold_pc", pc_if.pc, 16'h0000);
      drive(0, 1, 16'hFFFF, 0, 0, 0);
      step();
      drive(0, 1, 16'h0005, 1, 0, 0);
      step();
      check("wrap_sup_pc", pc_if.pc, 16'h0005);
      check("wrap_sup", pc_if.wrap, 0);

      drive(0, 0, 16'h0, 1, 1, 0);
      step();
      check("halt_pc", pc_if.pc, 16'h0006);
      check("halt_halted", pc_if.halted, 1);
      check("halt_valid", pc_if.pc_valid, 0);
      drive(0, 0, 16'h0, 1, 0, 0);
      step();
      check("halt_noinc_pc", pc_if.pc, 16'h0006);
      drive(0, 1, 16'h0100, 0, 0, 0);
      step();
      check("halt_load_pc", pc_if.pc, 16'h0100);
      check("halt_load_halted", pc_if.halted, 1);
      drive(0, 0, 16'h0, 0, 1, 1);
      step();
      check("halt_resume_both", pc_if.halted, 1);
      drive(0, 0, 16'h0, 0, 0, 1);
      step();
      check("resume_valid", pc_if.pc_valid, 1);
      check("resume_halted", pc_if.halted, 0);
      check("resume_pc", pc_if.pc, 16'h0100);

      drive(0, 1, 16'h0042, 0, 0, 0);
      step();
      check("pre_clear_pc", pc_if.pc, 16'h0042);
      drive(1, 1, 16'h0077, 1, 0, 0);
      step();
      check("clear_pc", pc_if.pc, 16'h0000);
      check("clear_valid", pc_if.pc_valid, 0);
      drive(0, 0, 16'h0, 0, 0, 0);
      step();
      check("post_clear_valid", pc_if.pc_valid, 1);
      check("post_clear_pc", pc_if.pc, 16'h0000);

      drive(0, 0, 16'h0, 1, 0, 0);
      step();
      check("pre_arst_pc", pc_if.pc, 16'h0001);
      #2 rst_n = 1'b0;
      #1;
      check("arst_pc", pc_if.pc, 16'h0000);
      check("arst_valid", pc_if.pc_valid, 0);
      check("arst_halted", pc_if.halted, 0);
      #3 rst_n = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/program_counter.md
# program_counter

Registered instruction-address generator sitting directly upstream of the instruction-fetch stage. It drives the next fetch address over a valid/ready handshake. It selects between clear, load, increment and hold using the layer-1 selector logic. A small control FSM gates address issue through boot, run and halt phases.

## Interface
- `WIDTH`, 16, address width in bits
- `RESET_VECTOR`, 0, address loaded on reset and on `clear`
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous: pc ← `RESET_VECTOR`, FSM → BOOT
- `load`  in  1  synchronous: pc ← `load_addr`
- `load_addr`  in  `WIDTH`  jump/branch target
- `halt`  in  1  request RUN → HALT
- `resume`  in  1  request HALT → RUN
- `pc`  out  `WIDTH`  current fetch address (registered)
- `pc_valid`  out  1  `pc` is offered to fetch stage
- `pc_ready`  in  1  fetch stage accepts `pc`
- `halted`  out  1  FSM in HALT
- `wrap`  out  1  one-cycle pulse: increment rolled all-ones → 0

## Operation
- One clock; reset is asynchronous and active-low.
- FSM states: BOOT, RUN, HALT. Moore outputs: `pc_valid` = (state==RUN), `halted` = (state==HALT).
- Transitions, in priority order:
  - `clear` → BOOT from any state.
  - BOOT → RUN unconditionally.
  - RUN with `halt` → HALT.
  - HALT with `resume` and not `halt` → RUN.
  - Otherwise hold.
- pc next-value priority: `clear` > `load` > increment > hold.
  - Increment only when state==RUN, `pc_valid` and `pc_ready` are all true.
  - `load` is honoured in every state, including HALT and BOOT.
- Increment is modulo 2^`WIDTH`. When pc == all-ones and an increment fires:
  - pc becomes 0.
  - `wrap` = 1 on the following cycle only.
  - A load or clear in the same cycle suppresses `wrap`.
- `halt` in RUN coinciding with a handshake: the handshake completes and pc increments. The FSM enters HALT next cycle.
- `load` coinciding with a handshake: the handshake completes (the fetch stage consumed the old pc), but pc takes `load_addr` and does not increment.
- `pc_valid` low ⇒ `pc_ready` is ignored.
- Reset values:
  - pc = `RESET_VECTOR`
  - state = BOOT
  - `pc_valid` = 0
  - `halted` = 0
  - `wrap` = 0
- Assertion of `rst_n` mid-operation immediately forces these values, regardless of clock.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- `load`/`clear` → new `pc` visible 1 cycle later.
- First `pc_valid` is 2 cycles after `rst_n` deasserts (BOOT occupies one cycle).
- Accepted handshake → pc+1 offered next cycle. With `pc_ready` held high: one address per cycle, no bubbles.
- `pc_ready` low: `pc` and `pc_valid` held stable (standard valid/ready rule; valid never drops without a handshake except via `halt`, `clear` or reset).
- `halt` → `pc_valid` low 1 cycle later. `resume` → `pc_valid` high 1 cycle later.

## Structure
- Shared package `cpu_pkg` holds:
  - `PC_WIDTH` (16)
  - `PC_RESET_VECTOR` (0)
  - the FSM state enum `pc_state_t` {BOOT, RUN, HALT}
- One sub-module, `pc_next_select`: purely combinational priority selector (clear/load/inc/hold) built from the layer-1 Mux/And/Or/Not cells. It also emits the `wrap_next` term. The register and FSM stay in `program_counter`.

## Test plan
- Reset/boot: hold `rst_n`=0, release → pc=0x0000, `pc_valid`=0 cycle 1, `pc_valid`=1 cycle 2.
- Stall and stream: `pc_ready` pattern 1,0,0,1,1 from pc=0x0000 → pc sequence 0,1,1,1,2,3. pc stays stable while stalled.
- Load during stall: pc=0x0010, `pc_ready`=0, `load`=1, `load_addr`=0x1234 → next cycle pc=0x1234, `pc_valid`=1. Load with handshake → 0x1234, not 0x0011.
- Wrap: `load_addr`=0xFFFF, then one handshake → pc=0x0000, `wrap`=1 for exactly one cycle.
- Halt/resume: `halt` with handshake at pc=0x0005 → pc=0x0006, `halted`=1, `pc_valid`=0. `load` 0x0100 while halted → pc=0x0100. `resume` → `pc_valid`=1 at 0x0100. `halt`+`resume` together in HALT → remains HALT.
- Clear vs. async reset mid-run: `clear` with `load` at pc=0x0042 → pc=0x0000, BOOT, `pc_valid`=0 for one cycle. Drop `rst_n` between clock edges → outputs reset immediately, before the next edge.
